// File: rtl/sdram_work_fsm.sv
// sdram_work_fsm
//
// Command-side work state machine of the SDRAM controller. After
// initialisation it grants refresh, then write, then read requests in that
// order. It walks ACT / READ / WRITE / AUTO-REFRESH sequences, using the
// phase-end flags returned by the timing block. The current state is reported
// back to that block, and the SDRAM command and address pins are decoded from
// the registered state.
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   init_done           no work is started while low
//   sdram_wr_req/rd_req level requests, held until acknowledged
//   sys_addr            {bank, row, col}, captured at grant
//   sdram_ref_req/ack   refresh handshake with the timing block
//   ref_domain          refresh window: blocks new read/write grants
//   end_*               single-cycle phase-end flags from the timing block
//   work_state          current state code
//   sdram_wr_ack/rd_ack one-cycle grant acknowledges (asserted during ACT)
//   sdram_busy          high whenever the FSM is not idle
//   sdram_cs_n..we_n    SDRAM command pins
//   sdram_ba/addr       SDRAM bank and address buses
//   sdram_dq_oe         DQ output enable (write data phase)
//
// ROW_W must be at least 11, because A10 carries the auto-precharge bit.
// COL_W must be at most 10.
`timescale 1ns/1ps
module sdram_work_fsm #(
    parameter int ROW_W = 12,
    parameter int COL_W = 9,
    parameter int BA_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      init_done,
    input  logic                      sdram_wr_req,
    input  logic                      sdram_rd_req,
    input  logic [BA_W+ROW_W+COL_W-1:0] sys_addr,
    input  logic                      sdram_ref_req,
    output logic                      sdram_ref_ack,
    input  logic                      ref_domain,
    input  logic                      end_trcd,
    input  logic                      end_tcl,
    input  logic                      end_tread,
    input  logic                      end_twait,
    input  logic                      end_twrite,
    input  logic                      end_tdal,
    input  logic                      end_trfc,
    output logic [4:0]                work_state,
    output logic                      sdram_wr_ack,
    output logic                      sdram_rd_ack,
    output logic                      sdram_busy,
    output logic                      sdram_cs_n,
    output logic                      sdram_ras_n,
    output logic                      sdram_cas_n,
    output logic                      sdram_we_n,
    output logic [BA_W-1:0]           sdram_ba,
    output logic [ROW_W-1:0]          sdram_addr,
    output logic                      sdram_dq_oe
);

    // Codes shared with the timing block; they must not be renumbered.
    typedef enum logic [4:0] {
        S_IDLE    = 5'd0,
        S_ACT     = 5'd1,
        S_TRCD    = 5'd2,
        S_RD      = 5'd3,
        S_CL      = 5'd4,
        S_RD_DATA = 5'd5,
        S_RWAIT   = 5'd6,
        S_WR      = 5'd7,
        S_WR_DATA = 5'd8,
        S_TDAL    = 5'd9,
        S_AR      = 5'd10,
        S_TRFC    = 5'd11,
        S_AR1     = 5'd12,
        S_TRFC1   = 5'd13
    } state_t;

    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_NOP   = 4'b0111;

    state_t            state;
    state_t            state_nxt;
    logic              grant_wr;
    logic              grant_rd;
    logic              op_wr;       // 1 = write, 0 = read
    logic [BA_W-1:0]   bank_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;

    function automatic logic [3:0] cmd_decode(input state_t s);
        case (s)
            S_ACT:        cmd_decode = CMD_ACT;
            S_RD:         cmd_decode = CMD_READ;
            S_WR:         cmd_decode = CMD_WRITE;
            S_AR, S_AR1:  cmd_decode = CMD_AREF;
            default:      cmd_decode = CMD_NOP;
        endcase
    endfunction

    // Column on the row-wide bus with A10 set, so every access auto-precharges.
    function automatic logic [ROW_W-1:0] col_addr(input logic [COL_W-1:0] c);
        logic [ROW_W-1:0] a;
        a     = ROW_W'(c);
        a[10] = 1'b1;
        return a;
    endfunction

    // Next-state logic and grant strobes.
    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!init_done) begin
                    state_nxt = S_IDLE;
                end else if (sdram_ref_req) begin
                    state_nxt = S_AR;
                end else if (sdram_wr_req && !ref_domain) begin
                    state_nxt = S_ACT;
                    grant_wr  = 1'b1;
                end else if (sdram_rd_req && !ref_domain) begin
                    state_nxt = S_ACT;
                    grant_rd  = 1'b1;
                end
            end
            S_ACT:     state_nxt = S_TRCD;
            S_TRCD:    if (end_trcd)   state_nxt = op_wr ? S_WR : S_RD;
            S_RD:      state_nxt = S_CL;
            S_CL:      if (end_tcl)    state_nxt = S_RD_DATA;
            S_RD_DATA: if (end_tread)  state_nxt = S_RWAIT;
            S_RWAIT:   if (end_twait)  state_nxt = S_IDLE;
            S_WR:      state_nxt = S_WR_DATA;
            S_WR_DATA: if (end_twrite) state_nxt = S_TDAL;
            S_TDAL:    if (end_tdal)   state_nxt = S_IDLE;
            S_AR:      state_nxt = S_TRFC;
            S_TRFC:    if (end_trfc)   state_nxt = S_AR1;
            S_AR1:     state_nxt = S_TRFC1;
            S_TRFC1:   if (end_trfc)   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operation and address are captured only on the grant cycle, so the
    // requester may change sys_addr once it has seen the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr  <= 1'b0;
            bank_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (grant_wr || grant_rd) begin
            op_wr                  <= grant_wr;
            {bank_q, row_q, col_q} <= sys_addr;
        end
    end

    // Output decode from registered state and latches only.
    assign work_state    = state;
    assign sdram_busy    = (state != S_IDLE);
    assign sdram_ref_ack = (state == S_AR);
    assign sdram_wr_ack  = (state == S_ACT) &&  op_wr;
    assign sdram_rd_ack  = (state == S_ACT) && !op_wr;
    assign sdram_dq_oe   = (state == S_WR) || (state == S_WR_DATA);
    assign sdram_ba      = bank_q;

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_decode(state);

    always_comb begin
        sdram_addr = '0;
        case (state)
            S_ACT:      sdram_addr = row_q;
            S_RD, S_WR: sdram_addr = col_addr(col_q);
            default:    sdram_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_sdram_work_fsm.sv
// Directed testbench for sdram_work_fsm. Inputs change and outputs are
// sampled on the falling edge. Every expected value is written out by hand.
`timescale 1ns/1ps
module tb_sdram_work_fsm;

    localparam int ROW_W = 12;
    localparam int COL_W = 9;
    localparam int BA_W  = 2;

    logic                       clk;
    logic                       rst_n;
    logic                       init_done;
    logic                       sdram_wr_req;
    logic                       sdram_rd_req;
    logic [BA_W+ROW_W+COL_W-1:0] sys_addr;
    logic                       sdram_ref_req;
    logic                       sdram_ref_ack;
    logic                       ref_domain;
    logic                       end_trcd, end_tcl, end_tread, end_twait;
    logic                       end_twrite, end_tdal, end_trfc;
    logic [4:0]                 work_state;
    logic                       sdram_wr_ack, sdram_rd_ack, sdram_busy;
    logic                       sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BA_W-1:0]            sdram_ba;
    logic [ROW_W-1:0]           sdram_addr;
    logic                       sdram_dq_oe;

    logic [3:0] cmd;
    assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

    int n_tests = 0;
    int n_fail  = 0;

    sdram_work_fsm #(.ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_done     (init_done),
        .sdram_wr_req  (sdram_wr_req),
        .sdram_rd_req  (sdram_rd_req),
        .sys_addr      (sys_addr),
        .sdram_ref_req (sdram_ref_req),
        .sdram_ref_ack (sdram_ref_ack),
        .ref_domain    (ref_domain),
        .end_trcd      (end_trcd),
        .end_tcl       (end_tcl),
        .end_tread     (end_tread),
        .end_twait     (end_twait),
        .end_twrite    (end_twrite),
        .end_tdal      (end_tdal),
        .end_trfc      (end_trfc),
        .work_state    (work_state),
        .sdram_wr_ack  (sdram_wr_ack),
        .sdram_rd_ack  (sdram_rd_ack),
        .sdram_busy    (sdram_busy),
        .sdram_cs_n    (sdram_cs_n),
        .sdram_ras_n   (sdram_ras_n),
        .sdram_cas_n   (sdram_cas_n),
        .sdram_we_n    (sdram_we_n),
        .sdram_ba      (sdram_ba),
        .sdram_addr    (sdram_addr),
        .sdram_dq_oe   (sdram_dq_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic flags(input logic v);
        end_trcd   = v;
        end_tcl    = v;
        end_tread  = v;
        end_twait  = v;
        end_twrite = v;
        end_tdal   = v;
        end_trfc   = v;
    endtask

    // Bounded wait for a state; an expired budget is reported as a failure.
    task automatic wait_state(input string tag, input logic [4:0] s, input int max_cyc);
        int n;
        n = 0;
        while (work_state !== s && n < max_cyc) begin
            step();
            n++;
        end
        chk(tag, 32'(work_state), 32'(s));
    endtask

    logic [4:0] rd_seq [7];
    int         non_idle;

    initial begin
        rd_seq = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0};

        rst_n         = 1'b0;
        init_done     = 1'b0;
        sdram_wr_req  = 1'b0;
        sdram_rd_req  = 1'b0;
        sdram_ref_req = 1'b0;
        ref_domain    = 1'b0;
        sys_addr      = '0;
        flags(1'b0);

        // ---------------- power-on reset values
        step(); step();
        chk("rst_state", 32'(work_state), 32'd0);
        chk("rst_cmd",   32'(cmd),        32'h7);
        chk("rst_addr",  32'(sdram_addr), 32'h0);
        chk("rst_ba",    32'(sdram_ba),   32'h0);
        chk("rst_busy",  32'(sdram_busy), 32'd0);
        chk("rst_acks",  32'({sdram_ref_ack, sdram_wr_ack, sdram_rd_ack}), 32'd0);
        chk("rst_dqoe",  32'(sdram_dq_oe), 32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- read, every flag on its first cycle
        init_done    = 1'b1;
        sdram_rd_req = 1'b1;
        sys_addr     = {2'd1, 12'h7FF, 9'h1FF};
        flags(1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("rd_seq%0d", i), 32'(work_state), 32'(rd_seq[i]));
            chk($sformatf("rd_ack%0d", i), 32'(sdram_rd_ack), 32'(rd_seq[i] == 5'd1));
            chk($sformatf("rd_dqoe%0d", i), 32'(sdram_dq_oe), 32'd0);
            if (rd_seq[i] == 5'd1) begin
                chk("rd_act_cmd",  32'(cmd),        32'h3);
                chk("rd_act_row",  32'(sdram_addr), 32'h7FF);
                chk("rd_act_ba",   32'(sdram_ba),   32'h1);
                sdram_rd_req = 1'b0;
            end
            if (rd_seq[i] == 5'd3) begin
                chk("rd_cmd",  32'(cmd),        32'h5);
                chk("rd_addr", 32'(sdram_addr), 32'h5FF);
            end
        end
        flags(1'b0);

        // ---------------- asynchronous reset in S_RD_DATA
        sdram_rd_req = 1'b1;
        end_trcd     = 1'b1;
        end_tcl      = 1'b1;
        step();
        sdram_rd_req = 1'b0;
        wait_state("reach_rd_data", 5'd5, 20);
        flags(1'b0);
        init_done    = 1'b0;
        sdram_wr_req = 1'b1;
        sys_addr     = {2'd2, 12'h0A5, 9'h033};
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(work_state), 32'd0);
        chk("async_rst_cmd",   32'(cmd),        32'h7);
        chk("async_rst_ba",    32'(sdram_ba),   32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("noinit_state", 32'(work_state), 32'd0);
            chk("noinit_ack",   32'(sdram_wr_ack), 32'd0);
        end

        // ---------------- write, with delayed flags
        init_done = 1'b1;
        step();
        chk("wr_act_state", 32'(work_state),   32'd1);
        chk("wr_act_cmd",   32'(cmd),          32'h3);
        chk("wr_act_ba",    32'(sdram_ba),     32'h2);
        chk("wr_act_row",   32'(sdram_addr),   32'h0A5);
        chk("wr_ack",       32'(sdram_wr_ack), 32'd1);
        chk("wr_no_rdack",  32'(sdram_rd_ack), 32'd0);
        sdram_wr_req = 1'b0;
        step();
        chk("wr_trcd0",     32'(work_state),   32'd2);
        chk("wr_ack_1cyc",  32'(sdram_wr_ack), 32'd0);
        step();
        chk("wr_trcd1",     32'(work_state),   32'd2);
        end_trcd = 1'b1;
        step();
        end_trcd = 1'b0;
        chk("wr_state",     32'(work_state),   32'd7);
        chk("wr_cmd",       32'(cmd),          32'h4);
        chk("wr_addr",      32'(sdram_addr),   32'h433);
        chk("wr_dqoe",      32'(sdram_dq_oe),  32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("wr_data%0d", i), 32'(work_state),  32'd8);
            chk($sformatf("wr_dqoe%0d", i), 32'(sdram_dq_oe), 32'd1);
            chk($sformatf("wr_nop%0d",  i), 32'(cmd),         32'h7);
            if (i == 3) end_twrite = 1'b1;
        end
        step();
        end_twrite = 1'b0;
        chk("wr_tdal0",      32'(work_state),  32'd9);
        chk("wr_tdal_dqoe",  32'(sdram_dq_oe), 32'd0);
        step();
        chk("wr_tdal1",      32'(work_state),  32'd9);
        end_tdal = 1'b1;
        step();
        end_tdal = 1'b0;
        chk("wr_done",       32'(work_state),  32'd0);
        chk("wr_done_busy",  32'(sdram_busy),  32'd0);

        // ---------------- refresh, write and read asserted together
        sdram_ref_req = 1'b1;
        sdram_wr_req  = 1'b1;
        sdram_rd_req  = 1'b1;
        sys_addr      = {2'd3, 12'h123, 9'h045};
        step();
        chk("sim_ar",       32'(work_state),    32'd10);
        chk("sim_ar_cmd",   32'(cmd),           32'h1);
        chk("sim_refack",   32'(sdram_ref_ack), 32'd1);
        chk("sim_no_wrack", 32'(sdram_wr_ack),  32'd0);
        sdram_ref_req = 1'b0;
        step();
        chk("sim_trfc",     32'(work_state),    32'd11);
        chk("sim_refack1",  32'(sdram_ref_ack), 32'd0);
        chk("sim_trfc_cmd", 32'(cmd),           32'h7);
        end_trfc = 1'b1;
        step();
        end_trfc = 1'b0;
        chk("sim_ar1",      32'(work_state),    32'd12);
        chk("sim_ar1_cmd",  32'(cmd),           32'h1);
        chk("sim_ar1_ack",  32'(sdram_ref_ack), 32'd0);
        end_trfc = 1'b1;
        step();
        end_trfc = 1'b0;
        chk("sim_trfc1",    32'(work_state),    32'd13);
        end_trfc = 1'b1;
        step();
        end_trfc = 1'b0;
        chk("sim_idle",     32'(work_state),    32'd0);
        step();
        chk("sim_wr_act",   32'(work_state),    32'd1);
        chk("sim_wr_ack",   32'(sdram_wr_ack),  32'd1);
        chk("sim_wr_row",   32'(sdram_addr),    32'h123);
        sdram_wr_req = 1'b0;
        end_trcd   = 1'b1;
        end_twrite = 1'b1;
        end_tdal   = 1'b1;
        // ACT, TRCD, WR, WR_DATA, TDAL, IDLE, then the pending read's ACT.
        for (int i = 0; i < 6; i++) step();
        chk("sim_rd_act",   32'(work_state),    32'd1);
        chk("sim_rd_ack",   32'(sdram_rd_ack),  32'd1);
        sdram_rd_req = 1'b0;
        flags(1'b1);
        wait_state("sim_rd_done", 5'd0, 20);
        flags(1'b0);

        // ---------------- refresh window holds off the read
        ref_domain   = 1'b1;
        sdram_rd_req = 1'b1;
        non_idle     = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (work_state !== 5'd0 || sdram_rd_ack !== 1'b0) non_idle++;
        end
        chk("refwin_blocked", 32'(non_idle), 32'd0);
        ref_domain = 1'b0;
        step();
        chk("refwin_act",   32'(work_state),   32'd1);
        chk("refwin_ack",   32'(sdram_rd_ack), 32'd1);
        sdram_rd_req = 1'b0;

        // ---------------- foreign flags ignored in S_TRCD
        step();
        chk("scope_trcd0",  32'(work_state), 32'd2);
        end_tcl  = 1'b1;
        end_trfc = 1'b1;
        step();
        end_tcl  = 1'b0;
        end_trfc = 1'b0;
        chk("scope_trcd1",  32'(work_state), 32'd2);
        step();
        chk("scope_trcd2",  32'(work_state), 32'd2);
        end_trcd = 1'b1;
        step();
        end_trcd = 1'b0;
        chk("scope_rd",     32'(work_state), 32'd3);
        flags(1'b1);
        wait_state("scope_done", 5'd0, 20);
        flags(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
